// File: rtl/parser_ingress_arb.sv
// Packet-granular round-robin arbiter feeding the parser receive port from N ingress sources.
// A watchdog terminates packets whose granted source goes silent mid-packet.
`timescale 1ns/1ps
module parser_ingress_arb #(
    parameter int          N       = 4,
    parameter logic [15:0] TIMEOUT = 16'd64,
    localparam int         GW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic [N*32-1:0] src_data,
    input  logic [N-1:0]    src_val,
    input  logic [N-1:0]    src_last,
    output logic [N-1:0]    src_ready,
    output logic [31:0]     dataIn,
    output logic            dataIn_val,
    output logic            dataIN_last,
    input  logic            dataIn_ready,
    output logic [GW-1:0]   grant_id,
    output logic            busy,
    output logic [15:0]     abort_count
);

    typedef enum logic [1:0] {IDLE, PASS, FLUSH, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] grant_q, grant_nxt;
    logic [GW-1:0] ptr_q, ptr_nxt;
    logic [15:0]   stall_cnt, stall_nxt;
    logic [15:0]   abort_q;
    logic          abort_evt;
    logic [16:0]   stall_inc;
    logic [31:0]   src_word [N];
    logic          g_val, g_last;
    logic [GW-1:0] pick, pick_hi, pick_lo;
    logic          found_hi, found_lo;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_word[i] = src_data[i*32 +: 32];
        end
    end

    assign g_val  = src_val[grant_q];
    assign g_last = src_last[grant_q];

    // Round-robin: prefer the lowest requester above ptr, else wrap to the lowest at or below it.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = 0; i < N; i++) begin
            if (src_val[i]) begin
                if (GW'(i) > ptr_q) begin
                    if (!found_hi) pick_hi = GW'(i);
                    found_hi = 1'b1;
                end else begin
                    if (!found_lo) pick_lo = GW'(i);
                    found_lo = 1'b1;
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    assign stall_inc = {1'b0, stall_cnt} + 17'd1;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        ptr_nxt   = ptr_q;
        stall_nxt = stall_cnt;
        abort_evt = 1'b0;
        case (state)
            IDLE: begin
                if (|src_val) begin
                    grant_nxt = pick;
                    ptr_nxt   = pick;
                    stall_nxt = '0;
                    state_nxt = PASS;
                end
            end
            PASS: begin
                if (g_val) begin
                    stall_nxt = '0;
                    if (dataIn_ready && g_last) state_nxt = IDLE;
                end else if (TIMEOUT != 16'd0 && stall_inc >= {1'b0, TIMEOUT}) begin
                    stall_nxt = '0;
                    abort_evt = 1'b1;
                    state_nxt = FLUSH;
                end else begin
                    stall_nxt = stall_inc[16] ? stall_cnt : stall_inc[15:0];
                end
            end
            FLUSH: begin
                if (dataIn_ready) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (g_val && g_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            grant_q   <= '0;
            ptr_q     <= GW'(N - 1);
            stall_cnt <= '0;
            abort_q   <= '0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            ptr_q     <= ptr_nxt;
            stall_cnt <= stall_nxt;
            if (abort_evt && abort_q != 16'hFFFF) abort_q <= abort_q + 16'd1;
        end
    end

    // Outputs decode from state only, so an asynchronous reset clears them immediately.
    always_comb begin
        src_ready   = '0;
        dataIn      = '0;
        dataIn_val  = 1'b0;
        dataIN_last = 1'b0;
        case (state)
            PASS: begin
                dataIn_val         = g_val;
                dataIn             = g_val ? src_word[grant_q] : 32'd0;
                dataIN_last        = g_val & g_last;
                src_ready[grant_q] = dataIn_ready;
            end
            FLUSH: begin
                dataIn_val  = 1'b1;
                dataIN_last = 1'b1;
            end
            DRAIN: begin
                src_ready[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_id    = grant_q;
    assign busy        = (state != IDLE);
    assign abort_count = abort_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_b) $onehot0(src_ready));
    a_quiet_bus: assert property (@(posedge clk) disable iff (!reset_b)
        !dataIn_val |-> (dataIn == 32'd0 && !dataIN_last));

endmodule

// File: doc/parser_ingress_arb.md
# parser_ingress_arb

Packet-granular round-robin arbiter that shares one `parser` receive interface between `N` independent 32-bit ingress sources. It grants one source at a time and passes that source's beats through to the parser until the packet's last beat is accepted. A stall watchdog terminates a packet whose source goes silent mid-packet, so one dead source cannot lock the parser. It sits directly in front of `parser` and drives its `dataIn`/`dataIn_val`/`dataIN_last`/`dataIn_ready` receive port.

## Interface
- `N`, 4: number of ingress sources (2..16).
- `TIMEOUT`, 64: consecutive granted-source idle cycles before abort; 0 disables the watchdog; 16-bit value.
- `clk` input 1: clock. One clock domain; all logic on `posedge clk`.
- `reset_b` input 1: reset. Asynchronous assert, active-low.
- `src_data` input N*32: source data; source i uses bits [32i+31:32i].
- `src_val` input N: per-source beat valid.
- `src_last` input N: per-source last beat of packet.
- `src_ready` output N: per-source beat accept.
- `dataIn` output 32: data to the parser.
- `dataIn_val` output 1: beat valid to the parser.
- `dataIN_last` output 1: last beat to the parser.
- `dataIn_ready` input 1: parser accept.
- `grant_id` output clog2(N): currently or most recently granted source.
- `busy` output 1: high in any state other than IDLE.
- `abort_count` output 16: number of watchdog aborts; saturates at 16'hFFFF.

## Operation
- A beat transfers on an interface when val and ready are both high on a clock edge.
- The block has four states: IDLE, PASS, FLUSH and DRAIN.
- **IDLE**
  - All `src_ready` are 0 and `dataIn_val` is 0.
  - If any `src_val` is high, grant the first requesting index searching upward from `ptr+1` (mod N). Load `grant_id` with that index, set `ptr` to it and go to PASS.
  - If no `src_val` is high, stay in IDLE.
- **PASS** (g = `grant_id`)
  - `dataIn`/`dataIn_val`/`dataIN_last` are combinationally equal to source g's data/val/last.
  - `src_ready[g]` equals `dataIn_ready`. All other `src_ready` are 0.
  - When a beat transfers with last high, go to IDLE.
- **Watchdog** (PASS only)
  - `stall_cnt` increments on each PASS cycle with `src_val[g]`=0.
  - It clears on any cycle with `src_val[g]`=1, including cycles where the parser backpressures. Parser backpressure never counts as a stall.
  - If TIMEOUT≠0 and `stall_cnt` reaches TIMEOUT: go to FLUSH and increment `abort_count` (saturating).
- **FLUSH**
  - Drive `dataIn`=0, `dataIn_val`=1, `dataIN_last`=1. All `src_ready` are 0.
  - On `dataIn_ready` high, go to DRAIN. The parser treats this synthetic terminator as a bad-length or short packet.
- **DRAIN**
  - `src_ready[g]`=1, `dataIn_val`=0.
  - Discard source g's beats. On a beat with last high, go to IDLE.
- `dataIn` and `dataIN_last` are 0 whenever `dataIn_val` is 0.
- Beat order within a packet is preserved. Packets are never interleaved.

## Timing
- **Reset values:** state IDLE, `src_ready`=0, `dataIn_val`=0, `dataIn`=0, `dataIN_last`=0, `grant_id`=0, `busy`=0, `abort_count`=0, `stall_cnt`=0, `ptr`=N-1 (so source 0 has first priority).
- **Reset mid-packet:** all outputs take their reset values immediately, without waiting for a clock edge. The partial packet is lost; the parser is reset alongside.
- **Arbitration latency:** 1 cycle. A request seen in IDLE at edge k is granted in PASS from cycle k+1.
- **Pass-through latency:** 0 cycles (combinational mux).
- **Throughput:** a k-beat packet with no backpressure occupies k+1 cycles (1 IDLE bubble per packet).
- **Last beat:** a last beat transferring in PASS returns the block to IDLE on the same edge. The next grant is decided in the following IDLE cycle.
- **Abort timing:** the watchdog reaches FLUSH on the TIMEOUT-th consecutive idle cycle. The terminator is held until `dataIn_ready` is high.
- **Source resumes during FLUSH:** the abort is already committed. The resumed beats are drained in DRAIN, not forwarded.
- **Round-robin pointer:** updates only when a grant is issued in IDLE.

## Test plan
1. **Single packet.** Source 0 sends 3 beats (0x11111111, 0x22222222, 0x33333333 with last), `dataIn_ready`=1.
   - Expect: one IDLE cycle, then the beats appear on `dataIn` on 3 consecutive cycles, `dataIN_last` on the third, `grant_id`=0, `busy` low on the following cycle.
2. **Fairness.** Sources 0 and 2 continuously offer 2-beat packets.
   - Expect: grant sequence 0,2,0,2; each packet takes 3 cycles; sources 1 and 3 are never granted.
3. **Parser backpressure.** Source 1 is mid-packet and `dataIn_ready` is low for 5 cycles with `src_val[1]` high.
   - Expect: `src_ready[1]`=0 and `dataIn` held for those cycles; no abort; `abort_count` stays 0.
4. **Watchdog abort.** TIMEOUT=4. Source 3 sends 1 beat, drops val for 4 cycles, then sends 2 more beats ending with last.
   - Expect: a terminator beat (`dataIn`=0, `dataIN_last`=1), `abort_count`=1, the 2 late beats consumed with `dataIn_val`=0, then return to IDLE.
5. **Watchdog disabled.** TIMEOUT=0, source stalls 1000 cycles.
   - Expect: stays in PASS, no terminator, `abort_count`=0.
6. **Asynchronous reset.** Assert `reset_b` low mid-packet, between clock edges.
   - Expect: `dataIn_val`, `src_ready` and `busy` are 0 before the next edge. After release, the first grant goes to the lowest-index requester.
